io_dev_port: RTL and testbench

- Device-side responder for the I/O unit's two device handshakes: supplies 5-bit input codes on the input rdy/val handshake and sinks 5-bit output codes on the output rdy/ack handshake.
- Sits between the I/O unit and a host-facing byte path (tape-reader/printer emulation, UART bridge or testbench).
- Each direction is buffered by a small FIFO.
- Host side uses a simple push/pop interface with full/empty flags.

---
 rtl/io_dev_pkg.sv | 22 ++
 rtl/io_dev_fifo.sv | 51 +++++
 rtl/io_dev_port.sv | 174 +++++++++++++++++
 tb/tb_io_dev_port.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_dev_pkg.sv
// io_dev_pkg: shared code constants and FSM encodings for the I/O device port.
package io_dev_pkg;

  typedef logic [4:0] code_t;

  localparam code_t CODE_WRITE    = 5'b00110;
  localparam code_t CODE_END      = 5'b00111;
  localparam code_t CODE_SEL      = 5'b00001;
  localparam code_t CODE_NUM_MASK = 5'b10000;

  // One-hot state encodings, two bits per FSM.
  localparam logic [1:0] IN_IDLE  = 2'b01;
  localparam logic [1:0] IN_VAL   = 2'b10;
  localparam logic [1:0] OUT_IDLE = 2'b01;
  localparam logic [1:0] OUT_ACK  = 2'b10;

  // The write code doubles as the end-of-record marker on the output path.
  function automatic logic is_eor(input code_t code);
    return code == CODE_WRITE;
  endfunction

endpackage

// File: rtl/io_dev_fifo.sv
// io_dev_fifo: synchronous FIFO with extended pointers. A push into a full
// FIFO is accepted when a pop happens in the same cycle; otherwise the
// push is dropped and reported on drop for one cycle.
module io_dev_fifo import io_dev_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr;
  logic [AW:0]      rd;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr == rd);
  assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign count   = wr - rd;
  assign rdata   = mem[rd[AW-1:0]];

  // Pointer advance; wrap comes for free from the extra MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_dev_port.sv
// io_dev_port: device-side responder for the I/O unit's input (rdy/val) and
// output (rdy/ack) handshakes, each direction buffered by an io_dev_fifo.
// Optional build macro IO_DEV_LOOPBACK_EN: when defined, loopback_en=1
// routes captured output codes into the input FIFO instead of the output FIFO.
//
// Input FSM
//   state    | meaning
//   IN_IDLE  | val low, waiting for rdy with a code queued
//   IN_VAL   | val high, code held until rdy drops; pop on the drop
// Output FSM
//   state    | meaning
//   OUT_IDLE | ack low, waiting for rdy with room downstream
//   OUT_ACK  | ack high, code already captured; wait for rdy to drop
module io_dev_port import io_dev_pkg::*; #(
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       input_rdy_from_io,
  output logic                       input_val_to_io,
  output logic [4:0]                 input_data_to_io,
  input  logic                       output_rdy_from_io,
  input  logic [4:0]                 output_data_from_io,
  output logic                       output_ack_to_io,
  input  logic                       host_in_push,
  input  logic [4:0]                 host_in_data,
  output logic                       host_in_full,
  output logic [$clog2(IN_DEPTH):0]  host_in_count,
  output logic                       host_in_overflow,
  input  logic                       host_out_pop,
  output logic [4:0]                 host_out_data,
  output logic                       host_out_empty,
  output logic                       host_out_eor,
  input  logic                       loopback_en
);

  logic [1:0] in_state;
  logic [1:0] out_state;

  logic  in_push;
  code_t in_wdata;
  logic  in_pop;
  code_t in_head;
  logic  in_empty;
  logic  in_drop;

  logic  out_push;
  logic  out_full;
  logic  out_drop_unused;
  logic [$clog2(OUT_DEPTH):0] out_count_unused;

  logic  room;
  logic  cap;
  logic  lb_collide;

  // The input code is consumed when the I/O unit drops rdy after seeing val.
  assign in_pop = (in_state == IN_VAL) && !input_rdy_from_io;
  assign cap    = (out_state == OUT_IDLE) && output_rdy_from_io && room;

`ifdef IO_DEV_LOOPBACK_EN
  logic lb_cap;
  assign lb_cap     = cap && loopback_en;
  assign room       = loopback_en ? !host_in_full : !out_full;
  assign in_push    = lb_cap || host_in_push;
  assign in_wdata   = lb_cap ? output_data_from_io : host_in_data;
  assign out_push   = cap && !loopback_en;
  // A looped-back code takes the write port; a coincident host push is lost.
  assign lb_collide = lb_cap && host_in_push;
`else
  logic unused_loopback;
  assign unused_loopback = loopback_en;
  assign room       = !out_full;
  assign in_push    = host_in_push;
  assign in_wdata   = host_in_data;
  assign out_push   = cap;
  assign lb_collide = 1'b0;
`endif

  io_dev_fifo #(.DEPTH(IN_DEPTH), .WIDTH(5)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .wdata (in_wdata),
    .pop   (in_pop),
    .rdata (in_head),
    .full  (host_in_full),
    .empty (in_empty),
    .count (host_in_count),
    .drop  (in_drop)
  );

  io_dev_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(5)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .wdata (output_data_from_io),
    .pop   (host_out_pop),
    .rdata (host_out_data),
    .full  (out_full),
    .empty (host_out_empty),
    .count (out_count_unused),
    .drop  (out_drop_unused)
  );

  // Input handshake: present the FIFO head, hold it until rdy falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state         <= IN_IDLE;
      input_val_to_io  <= 1'b0;
      input_data_to_io <= '0;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (input_rdy_from_io && !in_empty) begin
            in_state         <= IN_VAL;
            input_val_to_io  <= 1'b1;
            input_data_to_io <= in_head;
          end
        end
        IN_VAL: begin
          if (!input_rdy_from_io) begin
            in_state        <= IN_IDLE;
            input_val_to_io <= 1'b0;
          end
        end
        default: begin
          in_state        <= IN_IDLE;
          input_val_to_io <= 1'b0;
        end
      endcase
    end
  end

  // Output handshake: capture on rdy when there is room, ack until rdy falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state        <= OUT_IDLE;
      output_ack_to_io <= 1'b0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (cap) begin
            out_state        <= OUT_ACK;
            output_ack_to_io <= 1'b1;
          end
        end
        OUT_ACK: begin
          if (!output_rdy_from_io) begin
            out_state        <= OUT_IDLE;
            output_ack_to_io <= 1'b0;
          end
        end
        default: begin
          out_state        <= OUT_IDLE;
          output_ack_to_io <= 1'b0;
        end
      endcase
    end
  end

  // End-of-record pulse, one cycle after the capturing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) host_out_eor <= 1'b0;
    else       host_out_eor <= cap && is_eor(output_data_from_io);
  end

  // Sticky overflow: any host code that never made it into the input FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) host_in_overflow <= 1'b0;
    else if (in_drop || lb_collide) host_in_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_io_dev_port.sv
// tb_io_dev_port: directed bench for io_dev_port with a queue-based reference
// model compared on every falling clock edge, plus literal spot checks.
module tb_io_dev_port;
  localparam int IN_DEPTH  = 8;
  localparam int OUT_DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       input_rdy_from_io = 1'b0;
  logic       input_val_to_io;
  logic [4:0] input_data_to_io;
  logic       output_rdy_from_io = 1'b0;
  logic [4:0] output_data_from_io = 5'd0;
  logic       output_ack_to_io;
  logic       host_in_push = 1'b0;
  logic [4:0] host_in_data = 5'd0;
  logic       host_in_full;
  logic [$clog2(IN_DEPTH):0] host_in_count;
  logic       host_in_overflow;
  logic       host_out_pop = 1'b0;
  logic [4:0] host_out_data;
  logic       host_out_empty;
  logic       host_out_eor;
  logic       loopback_en = 1'b0;

  io_dev_port #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .input_rdy_from_io   (input_rdy_from_io),
    .input_val_to_io     (input_val_to_io),
    .input_data_to_io    (input_data_to_io),
    .output_rdy_from_io  (output_rdy_from_io),
    .output_data_from_io (output_data_from_io),
    .output_ack_to_io    (output_ack_to_io),
    .host_in_push        (host_in_push),
    .host_in_data        (host_in_data),
    .host_in_full        (host_in_full),
    .host_in_count       (host_in_count),
    .host_in_overflow    (host_in_overflow),
    .host_out_pop        (host_out_pop),
    .host_out_data       (host_out_data),
    .host_out_empty      (host_out_empty),
    .host_out_eor        (host_out_eor),
    .loopback_en         (loopback_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  int eor_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two code queues plus "presenting" / "acknowledging" flags.
  logic [4:0] in_q[$];
  logic [4:0] out_q[$];
  bit         m_val = 1'b0;
  bit         m_ack = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_eor = 1'b0;
  logic [4:0] m_data = 5'd0;

  always @(posedge clk or posedge reset) begin : mdl
    int in_sz;
    int out_sz;
    bit take;
    bit present;
    bit loop;
    bit accept;
    if (reset) begin
      in_q.delete();
      out_q.delete();
      m_val  = 1'b0;
      m_ack  = 1'b0;
      m_ovf  = 1'b0;
      m_eor  = 1'b0;
      m_data = 5'd0;
    end else begin
      in_sz   = in_q.size();
      out_sz  = out_q.size();
      take    = m_val && !input_rdy_from_io;
      present = !m_val && input_rdy_from_io && (in_sz > 0);
      loop    = 1'b0;
`ifdef IO_DEV_LOOPBACK_EN
      loop    = loopback_en;
`endif
      accept  = !m_ack && output_rdy_from_io &&
                (loop ? (in_sz < IN_DEPTH) : (out_sz < OUT_DEPTH));
      if (present) begin
        m_val  = 1'b1;
        m_data = in_q[0];
      end
      if (take) begin
        m_val = 1'b0;
        void'(in_q.pop_front());
      end
      if (accept && loop) begin
        in_q.push_back(output_data_from_io);
        if (host_in_push) m_ovf = 1'b1;
      end else if (host_in_push) begin
        if (in_sz < IN_DEPTH || take) in_q.push_back(host_in_data);
        else m_ovf = 1'b1;
      end
      if (host_out_pop && out_sz > 0) void'(out_q.pop_front());
      if (accept && !loop) out_q.push_back(output_data_from_io);
      m_eor = accept && (output_data_from_io == 5'b00110);
      if (m_ack && !output_rdy_from_io) m_ack = 1'b0;
      else if (accept) m_ack = 1'b1;
    end
  end

  // Every falling edge: all observable outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("val", 32'(input_val_to_io), 32'(m_val));
      chk("in_data", 32'(input_data_to_io), 32'(m_data));
      chk("ack", 32'(output_ack_to_io), 32'(m_ack));
      chk("in_full", 32'(host_in_full), 32'(in_q.size() == IN_DEPTH));
      chk("in_count", 32'(host_in_count), 32'(in_q.size()));
      chk("overflow", 32'(host_in_overflow), 32'(m_ovf));
      chk("out_empty", 32'(host_out_empty), 32'(out_q.size() == 0));
      if (out_q.size() > 0) chk("out_data", 32'(host_out_data), 32'(out_q[0]));
      chk("eor", 32'(host_out_eor), 32'(m_eor));
      if (host_out_eor) eor_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [4:0] d);
    host_in_push = 1'b1;
    host_in_data = d;
    step();
    host_in_push = 1'b0;
  endtask

  task automatic pop_out();
    host_out_pop = 1'b1;
    step();
    host_out_pop = 1'b0;
  endtask

  task automatic wait_val(input logic lvl, input string name);
    int n = 0;
    while (input_val_to_io !== lvl && n < 50) begin
      step();
      n++;
    end
    chk(name, 32'(input_val_to_io), 32'(lvl));
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string name);
    int n = 0;
    while (output_ack_to_io !== lvl && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(output_ack_to_io), 32'(lvl));
  endtask

  // I/O unit taking one input code: rdy up, see val, hold a cycle, rdy down.
  task automatic io_in_take(output logic [4:0] d);
    input_rdy_from_io = 1'b1;
    wait_val(1'b1, "val_rise");
    d = input_data_to_io;
    step();
    input_rdy_from_io = 1'b0;
    wait_val(1'b0, "val_fall");
  endtask

  // I/O unit delivering one output code.
  task automatic io_out_give(input logic [4:0] c);
    output_rdy_from_io  = 1'b1;
    output_data_from_io = c;
    wait_ack(1'b1, 50, "ack_rise");
    step();
    output_rdy_from_io = 1'b0;
    wait_ack(1'b0, 50, "ack_fall");
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [4:0] d;
    logic [4:0] out_codes[8];
    logic [4:0] fill[8];
    logic [4:0] drain_in[8];

    out_codes = '{5'b11111, 5'b10001, 5'b10010, 5'b10011,
                  5'b10100, 5'b10101, 5'b10110, 5'b10111};
    fill      = '{5'b00001, 5'b00010, 5'b00011, 5'b00100,
                  5'b00101, 5'b01000, 5'b01001, 5'b01010};
    drain_in  = '{5'b00010, 5'b00011, 5'b00100, 5'b00101,
                  5'b01000, 5'b01001, 5'b01010, 5'b11000};

    #1 reset = 1'b1;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_val", 32'(input_val_to_io), 32'd0);
    chk("rst_ack", 32'(output_ack_to_io), 32'd0);
    chk("rst_data", 32'(input_data_to_io), 32'd0);
    chk("rst_full", 32'(host_in_full), 32'd0);
    chk("rst_count", 32'(host_in_count), 32'd0);
    chk("rst_ovf", 32'(host_in_overflow), 32'd0);
    chk("rst_empty", 32'(host_out_empty), 32'd1);
    chk("rst_eor", 32'(host_out_eor), 32'd0);

    // Two input codes through the rdy/val handshake.
    push_in(5'b10011);
    push_in(5'b10101);
    chk("t1_count2", 32'(host_in_count), 32'd2);
    input_rdy_from_io = 1'b1;
    chk("t1_val_before", 32'(input_val_to_io), 32'd0);
    step();
    chk("t1_val_latency", 32'(input_val_to_io), 32'd1);
    io_in_take(d);
    chk("t1_data0", 32'(d), 32'h13);
    chk("t1_count1", 32'(host_in_count), 32'd1);
    io_in_take(d);
    chk("t1_data1", 32'(d), 32'h15);
    chk("t1_count0", 32'(host_in_count), 32'd0);

    // rdy sitting high on an empty FIFO, then a late push.
    input_rdy_from_io = 1'b1;
    repeat (20) step();
    chk("t2_no_val", 32'(input_val_to_io), 32'd0);
    push_in(5'b00111);
    chk("t2_val_plus1", 32'(input_val_to_io), 32'd0);
    step();
    chk("t2_val_plus2", 32'(input_val_to_io), 32'd1);
    io_in_take(d);
    chk("t2_data", 32'(d), 32'h07);

    // Eight output codes fill the output FIFO; the ninth is backpressured.
    for (int i = 0; i < 8; i++) io_out_give(out_codes[i]);
    output_rdy_from_io  = 1'b1;
    output_data_from_io = 5'b00110;
    repeat (6) step();
    chk("t3_ack_withheld", 32'(output_ack_to_io), 32'd0);
    chk("t3_no_eor_yet", 32'(eor_cnt), 32'd0);
    pop_out();
    wait_ack(1'b1, 10, "t3_ack_after_pop");
    chk("t3_head_after_pop", 32'(host_out_data), 32'h11);
    step();
    output_rdy_from_io = 1'b0;
    wait_ack(1'b0, 50, "t3_ack_fall");
    step();
    chk("t3_eor_once", 32'(eor_cnt), 32'd1);
    for (int i = 0; i < 8; i++) begin
      d = (i < 7) ? out_codes[i + 1] : 5'b00110;
      chk("t3_drain", 32'(host_out_data), 32'(d));
      pop_out();
    end
    chk("t3_empty", 32'(host_out_empty), 32'd1);
    chk("t3_eor_total", 32'(eor_cnt), 32'd1);

    // Input FIFO full: push+pop same cycle, then a dropped push.
    input_rdy_from_io = 1'b0;
    for (int i = 0; i < 8; i++) push_in(fill[i]);
    chk("t4_full", 32'(host_in_full), 32'd1);
    chk("t4_count8", 32'(host_in_count), 32'd8);
    input_rdy_from_io = 1'b1;
    wait_val(1'b1, "t4_val");
    step();
    input_rdy_from_io = 1'b0;
    host_in_push = 1'b1;
    host_in_data = 5'b11000;
    step();
    host_in_push = 1'b0;
    chk("t4_pushpop_count", 32'(host_in_count), 32'd8);
    chk("t4_pushpop_ovf", 32'(host_in_overflow), 32'd0);
    push_in(5'b10001);
    chk("t4_ovf", 32'(host_in_overflow), 32'd1);
    chk("t4_ovf_count", 32'(host_in_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      io_in_take(d);
      chk("t4_drain", 32'(d), 32'(drain_in[i]));
    end
    chk("t4_ovf_sticky", 32'(host_in_overflow), 32'd1);

    // Reset in the middle of both handshakes.
    push_in(5'b01010);
    input_rdy_from_io   = 1'b1;
    output_rdy_from_io  = 1'b1;
    output_data_from_io = 5'b10010;
    wait_val(1'b1, "t5_val");
    wait_ack(1'b1, 50, "t5_ack");
    #2 reset = 1'b1;
    #1;
    chk("t5_val_async", 32'(input_val_to_io), 32'd0);
    chk("t5_ack_async", 32'(output_ack_to_io), 32'd0);
    input_rdy_from_io  = 1'b0;
    output_rdy_from_io = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("t5_out_empty", 32'(host_out_empty), 32'd1);
    chk("t5_in_count", 32'(host_in_count), 32'd0);
    chk("t5_ovf_clear", 32'(host_in_overflow), 32'd0);

`ifdef IO_DEV_LOOPBACK_EN
    loopback_en = 1'b1;
    io_out_give(5'b10101);
    chk("t6_out_empty", 32'(host_out_empty), 32'd1);
    chk("t6_in_count", 32'(host_in_count), 32'd1);
    io_in_take(d);
    chk("t6_loop_data", 32'(d), 32'h15);
    loopback_en = 1'b0;
`endif

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
